// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the ALU arbiter: function codes, requester ids and
// the in-flight bookkeeping record.
package alu_arbiter_pkg;

  localparam logic [3:0] FUNC_ADD = 4'h0;
  localparam logic [3:0] FUNC_SLL = 4'h1;
  localparam logic [3:0] FUNC_LT  = 4'h2;
  localparam logic [3:0] FUNC_LTU = 4'h3;
  localparam logic [3:0] FUNC_XOR = 4'h4;
  localparam logic [3:0] FUNC_SRL = 4'h5;
  localparam logic [3:0] FUNC_OR  = 4'h6;
  localparam logic [3:0] FUNC_AND = 4'h7;
  localparam logic [3:0] FUNC_SUB = 4'h8;
  localparam logic [3:0] FUNC_SRA = 4'h9;
  localparam logic [3:0] FUNC_EQ  = 4'hA;
  localparam logic [3:0] FUNC_NE  = 4'hB;
  localparam logic [3:0] FUNC_LE  = 4'hC;
  localparam logic [3:0] FUNC_LEU = 4'hD;

  localparam logic REQ_EXEC = 1'b0;
  localparam logic REQ_BR   = 1'b1;

  typedef struct packed {
    logic valid;
    logic id;
    logic err;
  } infl_meta_t;

  function automatic logic FUNC_LEGAL(input logic [3:0] func);
    return func inside {FUNC_ADD, FUNC_SLL, FUNC_LT, FUNC_LTU, FUNC_XOR, FUNC_SRL, FUNC_OR,
                        FUNC_AND, FUNC_SUB, FUNC_SRA, FUNC_EQ, FUNC_NE, FUNC_LE, FUNC_LEU};
  endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response channels between the issue stage (master) and the ALU
// arbiter (slave), two ports each.
interface alu_arbiter_if #(
  parameter int unsigned TAG_W = 5
);

  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [3:0]       req_func0;
  logic [3:0]       req_func1;
  logic [31:0]      req_a0;
  logic [31:0]      req_b0;
  logic [31:0]      req_a1;
  logic [31:0]      req_b1;
  logic [TAG_W-1:0] req_tag0;
  logic [TAG_W-1:0] req_tag1;

  logic [1:0]       rsp_valid;
  logic [1:0]       rsp_ready;
  logic [31:0]      rsp_res0;
  logic [31:0]      rsp_res1;
  logic [TAG_W-1:0] rsp_tag0;
  logic [TAG_W-1:0] rsp_tag1;
  logic [1:0]       rsp_err;

  modport master (
    output req_valid, req_func0, req_func1, req_a0, req_b0, req_a1, req_b1,
           req_tag0, req_tag1, rsp_ready,
    input  req_ready, rsp_valid, rsp_res0, rsp_res1, rsp_tag0, rsp_tag1, rsp_err
  );

  modport slave (
    input  req_valid, req_func0, req_func1, req_a0, req_b0, req_a1, req_b1,
           req_tag0, req_tag1, rsp_ready,
    output req_ready, rsp_valid, rsp_res0, rsp_res1, rsp_tag0, rsp_tag1, rsp_err
  );

endinterface

// File: rtl/alu.sv
// Single-cycle ALU with a registered result; the result register only loads
// when enable is high. Unknown function codes produce 0.
module alu
  import alu_arbiter_pkg::*;
(
  input  logic        clock,
  input  logic        reset_n,
  input  logic        enable,
  input  logic [3:0]  func,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] result
);

  logic [31:0] result_d;

  always_comb begin
    result_d = '0;
    case (func)
      FUNC_ADD: result_d = a + b;
      FUNC_SUB: result_d = a - b;
      FUNC_AND: result_d = a & b;
      FUNC_OR:  result_d = a | b;
      FUNC_XOR: result_d = a ^ b;
      // Shift amounts use all 32 bits of b, so b >= 32 shifts everything out.
      FUNC_SLL: result_d = a << b;
      FUNC_SRL: result_d = a >> b;
      FUNC_SRA: result_d = 32'($signed(a) >>> b);
      FUNC_LT:  result_d = {31'b0, $signed(a) < $signed(b)};
      FUNC_LTU: result_d = {31'b0, a < b};
      FUNC_LE:  result_d = {31'b0, $signed(a) <= $signed(b)};
      FUNC_LEU: result_d = {31'b0, a <= b};
      FUNC_EQ:  result_d = {31'b0, a == b};
      FUNC_NE:  result_d = {31'b0, a != b};
      default:  result_d = '0;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      result <= '0;
    end else if (enable) begin
      result <= result_d;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one registered ALU between the execute and
// branch-compare requesters, with a one-entry response slot per port.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int unsigned TAG_W = 5
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          flush,
  alu_arbiter_if.slave  bus
);

  logic [1:0]       slot_free;
  logic [1:0]       elig;
  logic             grant;
  logic             win;
  logic             prio_q;

  infl_meta_t       infl_q;
  logic [TAG_W-1:0] infl_tag_q;

  logic [3:0]       win_func, hold_func_q, alu_func;
  logic [31:0]      win_a, win_b, hold_a_q, hold_b_q, alu_a, alu_b;
  logic [TAG_W-1:0] win_tag;
  logic [31:0]      alu_result;
  logic [31:0]      retire_res;

  logic [1:0]       pop;
  logic [1:0]       rsp_valid_d, rsp_valid_q;
  logic [1:0]       rsp_err_q;
  logic [31:0]      rsp_res0_q, rsp_res1_q;
  logic [TAG_W-1:0] rsp_tag0_q, rsp_tag1_q;

  // A port may issue only if its slot will have room when the result retires.
  always_comb begin
    slot_free[REQ_EXEC] = !(infl_q.valid && infl_q.id == REQ_EXEC) &&
                          (!rsp_valid_q[REQ_EXEC] || bus.rsp_ready[REQ_EXEC]);
    slot_free[REQ_BR]   = !(infl_q.valid && infl_q.id == REQ_BR) &&
                          (!rsp_valid_q[REQ_BR] || bus.rsp_ready[REQ_BR]);
    elig  = bus.req_valid & slot_free & {2{reset_n & ~flush}};
    grant = |elig;
    if (&elig) begin
      win = prio_q;
    end else begin
      win = elig[REQ_BR];
    end
    bus.req_ready = '0;
    if (grant) begin
      bus.req_ready[win] = 1'b1;
    end
  end

  // Without a grant the ALU keeps seeing the last issued operands.
  always_comb begin
    win_func = win ? bus.req_func1 : bus.req_func0;
    win_a    = win ? bus.req_a1    : bus.req_a0;
    win_b    = win ? bus.req_b1    : bus.req_b0;
    win_tag  = win ? bus.req_tag1  : bus.req_tag0;
    alu_func = grant ? win_func : hold_func_q;
    alu_a    = grant ? win_a    : hold_a_q;
    alu_b    = grant ? win_b    : hold_b_q;
  end

  alu u_alu (
    .clock   (clock),
    .reset_n (reset_n),
    .enable  (grant),
    .func    (alu_func),
    .a       (alu_a),
    .b       (alu_b),
    .result  (alu_result)
  );

  // A retire into a slot that is popping this cycle simply replaces it.
  always_comb begin
    pop         = rsp_valid_q & bus.rsp_ready;
    rsp_valid_d = rsp_valid_q & ~pop;
    if (infl_q.valid) begin
      rsp_valid_d[infl_q.id] = 1'b1;
    end
    if (flush) begin
      rsp_valid_d = '0;
    end
    retire_res = infl_q.err ? '0 : alu_result;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      prio_q      <= 1'b0;
      infl_q      <= '0;
      infl_tag_q  <= '0;
      hold_func_q <= '0;
      hold_a_q    <= '0;
      hold_b_q    <= '0;
      rsp_valid_q <= '0;
      rsp_err_q   <= '0;
      rsp_res0_q  <= '0;
      rsp_res1_q  <= '0;
      rsp_tag0_q  <= '0;
      rsp_tag1_q  <= '0;
    end else begin
      rsp_valid_q  <= rsp_valid_d;
      infl_q.valid <= grant;
      if (grant) begin
        prio_q      <= ~win;
        infl_q.id   <= win;
        infl_q.err  <= !FUNC_LEGAL(win_func);
        infl_tag_q  <= win_tag;
        hold_func_q <= win_func;
        hold_a_q    <= win_a;
        hold_b_q    <= win_b;
      end
      if (infl_q.valid && !flush) begin
        if (infl_q.id == REQ_EXEC) begin
          rsp_res0_q          <= retire_res;
          rsp_tag0_q          <= infl_tag_q;
          rsp_err_q[REQ_EXEC] <= infl_q.err;
        end else begin
          rsp_res1_q          <= retire_res;
          rsp_tag1_q          <= infl_tag_q;
          rsp_err_q[REQ_BR]   <= infl_q.err;
        end
      end
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_res0  = rsp_res0_q;
  assign bus.rsp_res1  = rsp_res1_q;
  assign bus.rsp_tag0  = rsp_tag0_q;
  assign bus.rsp_tag1  = rsp_tag1_q;

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Round-robin arbiter and sequencer sharing the single-cycle registered `alu` between two requesters: port 0 (integer execute) and port 1 (branch compare). It accepts operations over valid/ready request channels and issues at most one operation per cycle to the ALU. It returns each result, with the requester's tag, through a one-entry response slot per port. It sits between the decode/issue stage and the writeback and branch-resolution logic.

## Interface
- `TAG_W`, default 5: width of the opaque tag carried from request to response.
- `clock` input 1: sole clock, rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `flush` input 1: synchronous discard of the in-flight op and both response slots.
- `req_valid[1:0]` input 2: per-port request valid.
- `req_ready[1:0]` output 2: per-port request ready, equal to that port's grant this cycle.
- `req_func0`, `req_func1` input 4 each: ALU function code.
- `req_a0`, `req_b0`, `req_a1`, `req_b1` input 32 each: operands.
- `req_tag0`, `req_tag1` input `TAG_W` each: tags.
- `rsp_valid[1:0]` output 2: per-port response valid.
- `rsp_ready[1:0]` input 2: per-port response ready.
- `rsp_res0`, `rsp_res1` output 32 each: ALU result.
- `rsp_tag0`, `rsp_tag1` output `TAG_W` each: echoed tags.
- `rsp_err[1:0]` output 2: unsupported function code; the result is forced to 0.

## Operation
- Port `i` is eligible when both hold:
  - `req_valid[i]`=1.
  - `slot_free[i]`, defined as: no op in flight for `i`, and (`rsp_valid[i]`=0, or `rsp_ready[i]`=1 this cycle).
- Grant:
  - Only one eligible port → it wins.
  - Both eligible → the port named by the priority pointer `prio` wins.
  - After any grant, `prio` ← the loser's index, or the other index if there was no contention.
  - No eligible port → no grant and `prio` is held.
- The winner's func/a/b drive the ALU combinationally, with `alu.enable`=1 only in the grant cycle. With no grant, enable=0 and the operands hold their last value.
- At the grant edge the in-flight register records: valid, winner id, tag, and err.
  - err=1 when func is not one of the 14 defined codes (ADD, LT, LTU, AND, OR, XOR, SLL, SRL, SUB, SRA, EQ, NE, LE, LEU).
- At the following edge the in-flight entry retires into response slot `id`:
  - `rsp_res` ← ALU result, or 0 when err.
  - `rsp_tag` and `rsp_err` are loaded with it.
  - `rsp_valid` ← 1.
  - The in-flight register clears.
- A response pops on `rsp_valid[i] & rsp_ready[i]`. A pop and a retire into the same slot in the same cycle is legal: the new entry replaces the popped one.
- Compare ops return 32-bit 0/1 in `rsp_res`. Shifts use the full 32-bit `b` as passed; no masking is done here.
- `flush`=1:
  - No grant that cycle (`req_ready`=0).
  - The in-flight entry is dropped.
  - Both `rsp_valid` are cleared at the edge.
  - `prio` is kept.
- Reset (asynchronous, at any point mid-operation) clears:
  - in-flight valid, `rsp_valid`=0, `rsp_err`=0, `rsp_res`=0, `rsp_tag`=0.
  - `prio`=0.
  - `req_ready` is therefore 0 during reset.

## Timing
- Latency: request accepted at edge T → `rsp_valid` high in the cycle after edge T+1 (2 cycles).
- Throughput:
  - 1 op/cycle aggregate when both ports alternate.
  - At most 1 op per 2 cycles for a single port, because of its in-flight reservation.
- `req_ready` is combinational from `req_valid`, `rsp_valid`, `rsp_ready`, in-flight state, `flush` and `prio`. It never depends on the request payload.
- Request payload must be stable while `req_valid`=1 and `req_ready`=0. The response payload is stable while `rsp_valid`=1 and `rsp_ready`=0.

## Structure
- Shared package/include `codes.v` holds:
  - the 4-bit function code constants;
  - a `FUNC_LEGAL` helper (function or macro);
  - the requester id constants `REQ_EXEC`=0 and `REQ_BR`=1.
- One sub-module: the existing `alu`, instantiated once. The arbiter, in-flight register and response slots stay in `alu_arbiter`.

## Test plan
- **Reset mid-op:** port 0 issues an ADD, then `reset_n`=0 one cycle after acceptance → all outputs 0, no response appears after release, `prio`=0.
- **Single op:** port 0 issues ADD a=7, b=5, tag=3 at T → `rsp_valid[0]`=1 after T+1, `rsp_res0`=12, `rsp_tag0`=3, `rsp_err[0]`=0.
- **Contention:** both ports valid every cycle with rsp_ready=1, port 0 SUB 10-4, port 1 LT -1<1 → grants alternate 0,1,0,1; `rsp_res0`=6, `rsp_res1`=1.
- **Backpressure:** port 1 issues EQ 9==9 with `rsp_ready[1]`=0 → result 1 held. A second port-1 request sees `req_ready[1]`=0 until `rsp_ready[1]`=1, is granted in that pop cycle, and its result follows 2 cycles later.
- **Illegal func:** func=4'hF → `rsp_err`=1, `rsp_res`=0.
- **Flush:** flush asserted the cycle after a grant → no response ever appears, `req_ready`=0 that cycle, and the next request completes normally.
